// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the ALU issue slice.
// ALU opcodes, main-decoder aluop classes and the issue FSM state type.
package alu_issue_pkg;

   // ALU opcodes driven on alu_op
   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluBad = 4'b1111;

   // Main-decoder instruction classes
   localparam logic [1:0] AluopMem    = 2'b00;
   localparam logic [1:0] AluopBranch = 2'b01;
   localparam logic [1:0] AluopRtype  = 2'b10;
   localparam logic [1:0] AluopRsvd   = 2'b11;

   // R-type funct3 encodings handled here
   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3Or     = 3'b110;
   localparam logic [2:0] F3And    = 3'b111;

   // Branch funct3 encodings
   localparam logic [2:0] F3Beq = 3'b000;
   localparam logic [2:0] F3Bne = 3'b001;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StDone = 2'd2
   } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU-control decoder.
// Maps aluop/funct3/funct7b5 to an ALU opcode, an illegal flag and a branch flag.
// Optional feature macro: ALU_ISSUE_BRANCH_EN (restricts branches to BEQ/BNE).
module alu_op_decode
   import alu_issue_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] op,
   output logic       illegal,
   output logic       is_branch
);

   // Decode; anything not explicitly legal falls through to AluBad/illegal
   always_comb begin
      op        = AluBad;
      illegal   = 1'b1;
      is_branch = 1'b0;
      unique case (aluop)
         AluopMem: begin
            op      = AluAdd;
            illegal = 1'b0;
         end
         AluopBranch: begin
            is_branch = 1'b1;
`ifdef ALU_ISSUE_BRANCH_EN
            if (funct3 == F3Beq || funct3 == F3Bne) begin
               op      = AluSub;
               illegal = 1'b0;
            end
`else
            op      = AluSub;
            illegal = 1'b0;
`endif
         end
         AluopRtype: begin
            case (funct3)
               F3AddSub: begin
                  op      = funct7b5 ? AluSub : AluAdd;
                  illegal = 1'b0;
               end
               F3And: begin
                  op      = AluAnd;
                  illegal = 1'b0;
               end
               F3Or: begin
                  op      = AluOr;
                  illegal = 1'b0;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue stage in front of a combinational ALU.
// IDLE accepts a request and registers operands/opcode, EXEC lets the ALU
// settle for one cycle and captures its result, DONE holds the result until
// the consumer takes it (and can accept the next request on the same edge).
// Optional feature macro: ALU_ISSUE_BRANCH_EN (BEQ/BNE branch outcome).
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_aluop,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   output logic [DATA_W-1:0] alu_data1,
   output logic [DATA_W-1:0] alu_data2,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_illegal,
   output logic              out_branch_taken
);

   state_t     st_q, st_d;
   logic       accept;
   logic       illegal_q;
   logic [3:0] dec_op;
   logic       dec_illegal;
   logic       dec_is_branch;

   alu_op_decode u_decode (
      .aluop     (in_aluop),
      .funct3    (in_funct3),
      .funct7b5  (in_funct7b5),
      .op        (dec_op),
      .illegal   (dec_illegal),
      .is_branch (dec_is_branch)
   );

   // Next state and handshake outputs
   always_comb begin
      st_d      = st_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (st_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) st_d = StExec;
         end
         StExec: begin
            st_d = StDone;
         end
         StDone: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            if (out_ready) st_d = in_valid ? StExec : StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   assign accept = in_valid & in_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) st_q <= StIdle;
      else       st_q <= st_d;
   end

   // ALU-facing registers: loaded only on accept, held otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_data1 <= '0;
         alu_data2 <= '0;
         alu_op    <= 4'b0000;
         illegal_q <= 1'b0;
      end else if (accept) begin
         alu_data1 <= in_data1;
         alu_data2 <= in_data2;
         alu_op    <= dec_op;
         illegal_q <= dec_illegal;
      end
   end

   // Result capture at the closing edge of EXEC; illegal requests report 0/zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
      end else if (st_q == StExec) begin
         out_result  <= illegal_q ? '0 : alu_result;
         out_zero    <= illegal_q ? 1'b1 : alu_zero;
         out_illegal <= illegal_q;
      end
   end

`ifdef ALU_ISSUE_BRANCH_EN
   logic br_en_q;
   logic br_ne_q;

   // Remember branch kind at accept; only legal branches (BEQ/BNE) are enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         br_en_q <= 1'b0;
         br_ne_q <= 1'b0;
      end else if (accept) begin
         br_en_q <= dec_is_branch & ~dec_illegal;
         br_ne_q <= in_funct3[0];
      end
   end

   // Branch outcome captured alongside the result
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               out_branch_taken <= 1'b0;
      else if (st_q == StExec) out_branch_taken <= br_en_q & (br_ne_q ? ~alu_zero : alu_zero);
   end
`else
   logic unused_is_branch;
   assign unused_is_branch = dec_is_branch;
   assign out_branch_taken = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// A small behavioural ALU closes the alu_* loop.
module tb_alu_issue;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_aluop;
   logic [2:0]    in_funct3;
   logic          in_funct7b5;
   logic [DW-1:0] in_data1, in_data2;
   logic [DW-1:0] alu_data1, alu_data2;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic          out_zero;
   logic          out_illegal;
   logic          out_branch_taken;

   int checks = 0;
   int errors = 0;

`ifdef ALU_ISSUE_BRANCH_EN
   localparam logic BR_ON = 1'b1;
`else
   localparam logic BR_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_issue #(.DATA_W(DW)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_aluop         (in_aluop),
      .in_funct3        (in_funct3),
      .in_funct7b5      (in_funct7b5),
      .in_data1         (in_data1),
      .in_data2         (in_data2),
      .alu_data1        (alu_data1),
      .alu_data2        (alu_data2),
      .alu_op           (alu_op),
      .alu_result       (alu_result),
      .alu_zero         (alu_zero),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_zero         (out_zero),
      .out_illegal      (out_illegal),
      .out_branch_taken (out_branch_taken)
   );

   // Behavioural ALU: unknown opcodes return 0
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_data1 & alu_data2;
         4'b0001: alu_result = alu_data1 | alu_data2;
         4'b0010: alu_result = alu_data1 + alu_data2;
         4'b0110: alu_result = alu_data1 - alu_data2;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      in_valid    = 1'b1;
      in_aluop    = op;
      in_funct3   = f3;
      in_funct7b5 = f7;
      in_data1    = d1;
      in_data2    = d2;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      drive(2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      in_valid = 1'b0;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (alu_op !== 4'b0000 || alu_data1 !== '0 || alu_data2 !== '0) begin errors++;
         $display("FAIL rst_alu got op=%b d1=%0h d2=%0h exp 0", alu_op, alu_data1, alu_data2); end
      checks++; if ({out_result, out_zero, out_illegal, out_branch_taken} !== '0) begin errors++;
         $display("FAIL rst_out got res=%0h z=%b ill=%b br=%b exp 0", out_result, out_zero,
                  out_illegal, out_branch_taken); end
      reset = 1'b0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL rst_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      drive(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL add_ready got %b exp 1", in_ready); end
      step();  // edge N: accept
      in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0010 || alu_data1 !== 64'd5 || alu_data2 !== 64'd7) begin
         errors++; $display("FAIL add_alu got op=%b d1=%0d d2=%0d exp 0010 5 7", alu_op,
                            alu_data1, alu_data2); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
         $display("FAIL add_exec got valid=%b ready=%b exp 0 0", out_valid, in_ready); end
      step();  // edge N+1: out_valid is up when edge N+2 samples it
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL add_valid got %b exp 1", out_valid); end
      checks++; if (out_result !== 64'd12 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin
         errors++; $display("FAIL add_result got %0d z=%b ill=%b exp 12 0 0", out_result,
                            out_zero, out_illegal); end
      step();  // edge N+2: result taken
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL add_idle got valid=%b ready=%b exp 0 1", out_valid, in_ready); end
   endtask

   task automatic test_branch();
      out_ready = 1'b1;
      // BEQ 9-9
      drive(2'b01, 3'b000, 1'b0, 64'd9, 64'd9);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0110) begin errors++;
         $display("FAIL beq_op got %b exp 0110", alu_op); end
      step();
      checks++; if (out_zero !== 1'b1 || out_result !== '0 || out_illegal !== 1'b0) begin
         errors++; $display("FAIL beq_res got %0h z=%b ill=%b exp 0 1 0", out_result, out_zero,
                            out_illegal); end
      checks++; if (out_branch_taken !== BR_ON) begin errors++;
         $display("FAIL beq_taken got %b exp %b", out_branch_taken, BR_ON); end
      step();
      // BNE 9-9
      drive(2'b01, 3'b001, 1'b0, 64'd9, 64'd9);
      step(); in_valid = 1'b0; step();
      checks++; if (out_zero !== 1'b1 || out_branch_taken !== 1'b0) begin errors++;
         $display("FAIL bne_res got z=%b taken=%b exp 1 0", out_zero, out_branch_taken); end
      step();
      // BNE 9-4: not equal, taken when the feature is on
      drive(2'b01, 3'b001, 1'b0, 64'd9, 64'd4);
      step(); in_valid = 1'b0; step();
      checks++; if (out_zero !== 1'b0 || out_branch_taken !== BR_ON) begin errors++;
         $display("FAIL bne_ne got z=%b taken=%b exp 0 %b", out_zero, out_branch_taken, BR_ON);
      end
      step();
      // Branch funct3 100: illegal with the feature, plain SUB without
      drive(2'b01, 3'b100, 1'b0, 64'd9, 64'd4);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== (BR_ON ? 4'b1111 : 4'b0110)) begin errors++;
         $display("FAIL br100_op got %b exp %b", alu_op, BR_ON ? 4'b1111 : 4'b0110); end
      step();
      checks++; if (out_illegal !== BR_ON || out_result !== (BR_ON ? 64'd0 : 64'd5)
                    || out_zero !== BR_ON || out_branch_taken !== 1'b0) begin errors++;
         $display("FAIL br100_res got ill=%b res=%0d z=%b taken=%b exp ill=%b", out_illegal,
                  out_result, out_zero, out_branch_taken, BR_ON); end
      step();
   endtask

   task automatic test_logic();
      out_ready = 1'b1;
      drive(2'b10, 3'b111, 1'b0, 64'hF0F0, 64'h0FF0);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0000) begin errors++;
         $display("FAIL and_op got %b exp 0000", alu_op); end
      step();
      checks++; if (out_result !== 64'h00F0 || out_zero !== 1'b0) begin errors++;
         $display("FAIL and_res got %0h z=%b exp f0 0", out_result, out_zero); end
      step();
      drive(2'b10, 3'b110, 1'b0, 64'hF0F0, 64'h0FF0);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0001) begin errors++;
         $display("FAIL or_op got %b exp 0001", alu_op); end
      step();
      checks++; if (out_result !== 64'hFFF0) begin errors++;
         $display("FAIL or_res got %0h exp fff0", out_result); end
      step();
      // R-type SUB with wrap
      drive(2'b10, 3'b000, 1'b1, 64'd3, 64'd5);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0110) begin errors++;
         $display("FAIL sub_op got %b exp 0110", alu_op); end
      step();
      checks++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++;
         $display("FAIL sub_res got %0h exp fffffffffffffffe", out_result); end
      step();
      // Load/store address add
      drive(2'b00, 3'b011, 1'b1, 64'd100, 64'd24);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0010) begin errors++;
         $display("FAIL mem_op got %b exp 0010", alu_op); end
      step();
      checks++; if (out_result !== 64'd124) begin errors++;
         $display("FAIL mem_res got %0d exp 124", out_result); end
      step();
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      drive(2'b11, 3'b000, 1'b0, 64'd8, 64'd3);
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b1111) begin errors++;
         $display("FAIL rsvd_op got %b exp 1111", alu_op); end
      step();
      checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== '0
                    || out_zero !== 1'b1) begin errors++;
         $display("FAIL rsvd_res got v=%b ill=%b res=%0h z=%b exp 1 1 0 1", out_valid,
                  out_illegal, out_result, out_zero); end
      step();
      drive(2'b10, 3'b010, 1'b0, 64'd8, 64'd3);
      step(); in_valid = 1'b0; step();
      checks++; if (out_illegal !== 1'b1 || out_result !== '0 || out_zero !== 1'b1) begin
         errors++; $display("FAIL rt010_res got ill=%b res=%0h z=%b exp 1 0 1", out_illegal,
                            out_result, out_zero); end
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(2'b10, 3'b000, 1'b0, 64'd1, 64'd2);
      step();
      drive(2'b10, 3'b110, 1'b0, 64'd6, 64'd9);  // next request waits during the stall
      step();
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || out_result !== 64'd3 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_%0d got v=%b res=%0d rdy=%b exp 1 3 0", i,
                               out_valid, out_result, in_ready); end
         checks++; if (alu_op !== 4'b0010 || alu_data1 !== 64'd1) begin errors++;
            $display("FAIL stall_hold_%0d got op=%b d1=%0d exp 0010 1", i, alu_op, alu_data1);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL b2b_ready got %b exp 1", in_ready); end
      step(); in_valid = 1'b0;
      checks++; if (alu_op !== 4'b0001 || alu_data1 !== 64'd6 || out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_accept got op=%b d1=%0d v=%b exp 0001 6 0", alu_op,
                            alu_data1, out_valid); end
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== 64'd15) begin errors++;
         $display("FAIL b2b_res got v=%b res=%0d exp 1 15", out_valid, out_result); end
      step();
   endtask

   task automatic test_reset_exec();
      logic seen;
      out_ready = 1'b1;
      drive(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
      step(); in_valid = 1'b0;  // now in EXEC
      reset = 1'b1;
      #1;
      checks++; if (alu_op !== 4'b0000 || alu_data1 !== '0 || alu_data2 !== '0
                    || out_valid !== 1'b0) begin errors++;
         $display("FAIL rexec_alu got op=%b d1=%0d d2=%0d v=%b exp 0", alu_op, alu_data1,
                  alu_data2, out_valid); end
      checks++; if ({out_result, out_zero, out_illegal, out_branch_taken} !== '0) begin
         errors++; $display("FAIL rexec_out got res=%0d z=%b ill=%b br=%b exp 0", out_result,
                            out_zero, out_illegal, out_branch_taken); end
      step();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++;
         $display("FAIL rexec_pulse got out_valid pulse exp none"); end
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL rexec_ready got %b exp 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_logic();
      test_illegal();
      test_back_to_back();
      test_reset_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 in_aluop  input  2  main-decoder class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
REQ-007 in_funct3  input  3  instruction funct3.
REQ-008 in_funct7b5  input  1  instruction bit 30.
REQ-009 in_data1, in_data2  input  DATA_W  operands.
REQ-010 alu_data1, alu_data2  output  DATA_W  operands driven to the ALU.
REQ-011 alu_op  output  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-012 alu_result  input  DATA_W, alu_zero  input  1  combinational ALU return.
REQ-013 out_valid  output  1, out_ready  input  1  downstream handshake.
REQ-014 out_result  output  DATA_W, out_zero  output  1  captured ALU result and zero flag.
REQ-015 out_illegal  output  1  request had no legal ALU encoding.
REQ-016 out_branch_taken  output  1  branch outcome (see Configuration).

Function
REQ-017 Decode: aluop 00 -> 0010; 01 -> 0110; 10 with funct3 000/f7b5 0 -> 0010, 000/1 -> 0110, 111 -> 0000, 110 -> 0001; any other combination -> 1111 with illegal set.
REQ-018 FSM states IDLE, EXEC, DONE; transfer occurs when valid and ready are both 1 on a rising edge.
REQ-019 in_ready = 1 in IDLE, = out_ready in DONE, = 0 in EXEC.
REQ-020 Accept: register in_data1/in_data2/decoded op/illegal into alu_data1/alu_data2/alu_op; go to EXEC.
REQ-021 EXEC lasts exactly one cycle; at its closing edge capture alu_result/alu_zero into out_result/out_zero, go to DONE.
REQ-022 Latency: accept at edge N -> out_valid high from edge N+2.
REQ-023 DONE: out_valid = 1; out_* stable until out_ready; on out_ready with in_valid go to EXEC (back-to-back, new request accepted same edge), with no in_valid go to IDLE.
REQ-024 ALU-facing registers hold last values in IDLE/DONE; no combinational path from in_* to alu_* or out_*.
REQ-025 Illegal request: still traverses EXEC/DONE; out_illegal = 1, out_result = 0 (ALU default), out_zero = 1.
REQ-026 Arithmetic wrap modulo 2^DATA_W is the ALU's; block performs no width extension.

Reset
REQ-027 reset asserted: state IDLE, all alu_* and out_* outputs 0, out_valid 0, in-flight request discarded without output.
REQ-028 in_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro ALU_ISSUE_BRANCH_EN defined: out_branch_taken captured in EXEC = alu_zero when request aluop = 01 and funct3 = 000 (BEQ), = !alu_zero for funct3 = 001 (BNE), else 0; other branch funct3 with aluop 01 sets out_illegal.
REQ-030 Macro undefined: out_branch_taken tied 0; aluop 01 decodes to SUB regardless of funct3.

Structure
REQ-031 Package alu_issue_pkg holds ALU opcode constants, aluop class constants, FSM state type.
REQ-032 Combinational sub-module alu_op_decode (aluop, funct3, funct7b5 -> op, illegal, is_branch).

Verification
REQ-033 R-type ADD 5 + 7, out_ready=1 -> alu_op 0010, out_result 12, out_zero 0, out_valid at edge N+2.
REQ-034 aluop 01, 9 - 9, BNE/BEQ with macro on -> out_zero 1, BEQ taken 1, BNE taken 0; macro off -> taken 0.
REQ-035 funct3 111 AND 0xF0F0 & 0x0FF0 -> 0x00F0; funct3 110 OR -> 0xFFF0.
REQ-036 aluop 11 -> out_illegal 1, out_result 0, out_zero 1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_* stable, in_ready 0; then out_ready=1 with in_valid -> next request accepted same edge, results 2 cycles later.
REQ-038 reset asserted during EXEC -> all outputs 0 immediately, no out_valid pulse afterwards.
